// File: rtl/bpsk_chip_demodulator.sv
// BPSK chip demodulator.
// Centres offset-binary samples and multiplies them by a +/-1 square-wave
// carrier reference. The products are integrated over one chip, then the
// result is dumped as a signed correlation value and a hard chip decision.
module bpsk_chip_demodulator #(
  parameter int DATA_W            = 12,
  parameter int SAMPLES_PER_CYCLE = 32,
  parameter int CYCLES_PER_CHIP   = 4,
  parameter int ACC_W             = 24
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              chip_out,
  output logic              chip_valid,
  output logic [ACC_W-1:0]  corr_out,
  output logic              busy
);

  localparam int N     = SAMPLES_PER_CYCLE * CYCLES_PER_CHIP;
  localparam int PH_W  = $clog2(SAMPLES_PER_CYCLE);
  localparam int CNT_W = $clog2(N);

  typedef enum logic {IDLE, INTEGRATE} state_t;

  state_t             state_q;
  logic [PH_W-1:0]    phase_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               chip_out_q;
  logic               chip_valid_q;
  logic [ACC_W-1:0]   corr_out_q;
  logic               busy_q;

  // Flipping the MSB of an offset-binary sample gives a two's-complement
  // value; one extra sign bit makes it the (DATA_W+1)-bit centred sample.
  logic [DATA_W:0]    centred;
  logic [ACC_W-1:0]   ext;
  logic               ref_pos;
  logic [ACC_W-1:0]   prod;
  logic [ACC_W-1:0]   acc_d;
  logic [PH_W-1:0]    phase_d;
  logic               last_sample;

  assign centred     = {{2{~sample_in[DATA_W-1]}}, sample_in[DATA_W-2:0]};
  assign ext         = {{(ACC_W-DATA_W-1){centred[DATA_W]}}, centred};
  assign ref_pos     = (phase_q < PH_W'(SAMPLES_PER_CYCLE / 2));
  assign prod        = ref_pos ? ext : (~ext + ACC_W'(1));
  assign acc_d       = acc_q + prod;
  assign phase_d     = (phase_q == PH_W'(SAMPLES_PER_CYCLE - 1)) ? '0 : phase_q + PH_W'(1);
  assign last_sample = (cnt_q == CNT_W'(N - 1));

  // Control FSM, integrator and registered outputs. start takes priority
  // over a coincident dump and always restarts the chip from index 0.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
      corr_out_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      chip_valid_q <= 1'b0;
      if (start) begin
        state_q <= INTEGRATE;
        busy_q  <= 1'b1;
        if (sample_valid) begin
          // Sample taken as phase 0 (ref = +1), index 0.
          acc_q   <= ext;
          phase_q <= PH_W'(1);
          cnt_q   <= CNT_W'(1);
        end else begin
          acc_q   <= '0;
          phase_q <= '0;
          cnt_q   <= '0;
        end
      end else if (state_q == INTEGRATE && sample_valid) begin
        if (last_sample) begin
          corr_out_q   <= acc_d;
          chip_out_q   <= ~acc_d[ACC_W-1];
          chip_valid_q <= 1'b1;
          acc_q        <= '0;
          phase_q      <= '0;
          cnt_q        <= '0;
        end else begin
          acc_q   <= acc_d;
          phase_q <= phase_d;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign chip_out   = chip_out_q;
  assign chip_valid = chip_valid_q;
  assign corr_out   = corr_out_q;
  assign busy       = busy_q;

endmodule
